// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD panel bus capture block.
// Holds the panel geometry, the capture state encoding and the pixel
// shade type used by lcd_capture and its helpers.
package lcd_pkg;

  localparam int LCD_WIDTH  = 160;
  localparam int LCD_HEIGHT = 144;
  localparam int LCD_ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    ACTIVE     = 2'd2
  } lcd_state_e;

  typedef logic [1:0] lcd_shade_t;

endpackage

// File: rtl/lcd_sync_edge.sv
// N-stage synchronizer followed by a rising-edge detector.
// Ports:
//   clk, reset : capture clock, asynchronous active-high reset
//   din        : asynchronous panel signal
//   level_r    : synchronized level (also the edge-detect history flop)
//   rise_r     : one-cycle pulse on a synchronized 0->1 transition
// din to rise_r latency is STAGES+1 clk cycles.
module lcd_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level_r,
  output logic rise_r
);

  logic [STAGES-1:0] sync_r;

  // Synchronizer chain, edge-detect history and registered rise pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r  <= {STAGES{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[STAGES-2:0], din};
      level_r <= sync_r[STAGES-1];
      rise_r  <= sync_r[STAGES-1] & ~level_r;
    end
  end

endmodule

// File: rtl/lcd_capture.sv
// Receive side of the LH507x LCD panel bus. Samples the panel signals,
// rebuilds pixel coordinates and emits one framebuffer write per pixel,
// flagging line-length and frame-structure violations as pulses.
// Ports:
//   clk, reset          : capture clock (>= 4x pixel clock), async reset
//   disp_on             : display enable, low forces IDLE
//   lcd_hsync/vsync/latch/clk/data : panel bus (positive phase)
//   px_valid/x/y/addr/data : registered framebuffer write
//   frame_start/frame_done : frame boundary pulses
//   err_line/overrun/frame : protocol violation pulses
module lcd_capture
  import lcd_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_on,
  input  logic                  lcd_hsync,
  input  logic                  lcd_vsync,
  input  logic                  lcd_latch,
  input  logic                  lcd_clk,
  input  logic [1:0]            lcd_data,
  output logic                  px_valid,
  output logic [7:0]            px_x,
  output logic [7:0]            px_y,
  output logic [LCD_ADDR_W-1:0] px_addr,
  output logic [1:0]            px_data,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  err_line,
  output logic                  err_overrun,
  output logic                  err_frame
);

  localparam logic [7:0] WIDTH_C  = 8'(WIDTH);
  localparam logic [7:0] LAST_Y_C = 8'(HEIGHT - 1);

  logic vsync_level_s, vsync_rise_s;
  logic latch_level_s, latch_rise_s;
  logic pclk_level_s,  pclk_rise_s;

  // {hsync, data} run one flop deeper than the plain synchronizer so they
  // line up with the registered rise pulses.
  logic [SYNC_STAGES:0][2:0] bus_r;
  lcd_shade_t                data_s;
  logic                      hsync_s;
  logic                      unused_s;

  lcd_state_e            state_r, state_s;
  logic [7:0]            x_r, x_s, x_inc_s;
  logic [7:0]            y_r, y_s;
  logic                  valid_s, fs_s, fd_s, el_s, eo_s, ef_s;
  logic [7:0]            px_x_s, px_y_s;
  logic [LCD_ADDR_W-1:0] px_addr_s;
  lcd_shade_t            px_data_s;

  lcd_sync_edge #(.STAGES(SYNC_STAGES)) u_vsync (
    .clk(clk), .reset(reset), .din(lcd_vsync),
    .level_r(vsync_level_s), .rise_r(vsync_rise_s));

  lcd_sync_edge #(.STAGES(SYNC_STAGES)) u_latch (
    .clk(clk), .reset(reset), .din(lcd_latch),
    .level_r(latch_level_s), .rise_r(latch_rise_s));

  lcd_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk (
    .clk(clk), .reset(reset), .din(lcd_clk),
    .level_r(pclk_level_s), .rise_r(pclk_rise_s));

  // Data/hsync synchronizer, depth matched to the pclk rise path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_r <= {(SYNC_STAGES+1){3'b000}};
    end else begin
      bus_r <= {bus_r[SYNC_STAGES-1:0], {lcd_hsync, lcd_data}};
    end
  end

  assign data_s  = bus_r[SYNC_STAGES][1:0];
  assign hsync_s = bus_r[SYNC_STAGES][2];
  // hsync only carries an idle expectation with no reporting output, and the
  // raw levels are not needed once edges are extracted.
  assign unused_s = ^{hsync_s, vsync_level_s, latch_level_s, pclk_level_s};

  // Next-state, counter and output decode.
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    x_inc_s   = x_r;
    valid_s   = 1'b0;
    fs_s      = 1'b0;
    fd_s      = 1'b0;
    el_s      = 1'b0;
    eo_s      = 1'b0;
    ef_s      = 1'b0;
    px_x_s    = px_x;
    px_y_s    = px_y;
    px_addr_s = px_addr;
    px_data_s = px_data;
    if (!disp_on) begin
      state_s = IDLE;
      x_s     = 8'd0;
      y_s     = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (vsync_rise_s) begin
            state_s = ACTIVE;
            x_s     = 8'd0;
            y_s     = 8'd0;
            fs_s    = 1'b1;
          end else begin
            state_s = WAIT_VSYNC;
          end
        end
        ACTIVE: begin
          if (vsync_rise_s) begin
            // vsync overrides any pixel or latch in the same cycle
            ef_s = 1'b1;
            fs_s = 1'b1;
            x_s  = 8'd0;
            y_s  = 8'd0;
          end else begin
            if (pclk_rise_s) begin
              if (x_r < WIDTH_C) begin
                valid_s   = 1'b1;
                px_x_s    = x_r;
                px_y_s    = y_r;
                px_addr_s = LCD_ADDR_W'(y_r) * LCD_ADDR_W'(WIDTH) + LCD_ADDR_W'(x_r);
                px_data_s = data_s;
                x_inc_s   = x_r + 8'd1;
              end else begin
                eo_s = 1'b1;
              end
            end else begin
              x_inc_s = x_r;
            end
            // a coincident pixel lands on the closing line first
            if (latch_rise_s) begin
              el_s = (x_inc_s != WIDTH_C);
              x_s  = 8'd0;
              if (y_r == LAST_Y_C) begin
                fd_s    = 1'b1;
                y_s     = 8'd0;
                state_s = WAIT_VSYNC;
              end else begin
                y_s = y_r + 8'd1;
              end
            end else begin
              x_s = x_inc_s;
            end
          end
        end
        default: begin
          state_s = IDLE;
          x_s     = 8'd0;
          y_s     = 8'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      x_r         <= 8'd0;
      y_r         <= 8'd0;
      px_valid    <= 1'b0;
      px_x        <= 8'd0;
      px_y        <= 8'd0;
      px_addr     <= {LCD_ADDR_W{1'b0}};
      px_data     <= 2'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_line    <= 1'b0;
      err_overrun <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      state_r     <= state_s;
      x_r         <= x_s;
      y_r         <= y_s;
      px_valid    <= valid_s;
      px_x        <= px_x_s;
      px_y        <= px_y_s;
      px_addr     <= px_addr_s;
      px_data     <= px_data_s;
      frame_start <= fs_s;
      frame_done  <= fd_s;
      err_line    <= el_s;
      err_overrun <= eo_s;
      err_frame   <= ef_s;
    end
  end

endmodule

// File: doc/lcd_capture.md
Name: lcd_capture

Overview:
- Receive side of the LH507x LCD panel bus: samples the positive-phase panel signals driven out to the display (hsync, vsync, latch, pixel clock, 2-bit pixel data).
- Rebuilds pixel coordinates and emits one framebuffer write per pixel.
- Sits beside the LCD output path; feeds the debug framebuffer / video scaler.
- Checks line length and frame structure, and reports violations as single-cycle error pulses.

Parameters:
- WIDTH, 160, active pixels per line.
- HEIGHT, 144, active lines per frame.
- SYNC_STAGES, 2, synchronizer flops per input (minimum 2).

Ports:
- clk  in  1  capture clock; at least 4x the panel pixel clock rate.
- reset  in  1  asynchronous, active-high reset.
- disp_on  in  1  display enable; low forces IDLE.
- lcd_hsync  in  1  panel hsync (positive phase); used only for the idle check.
- lcd_vsync  in  1  panel vsync; rising edge starts a frame.
- lcd_latch  in  1  panel line latch; rising edge closes the current line.
- lcd_clk  in  1  panel pixel clock; rising edge qualifies lcd_data.
- lcd_data  in  2  panel pixel data.
- px_valid  out  1  one-cycle pixel write strobe.
- px_x  out  8  pixel column.
- px_y  out  8  pixel row.
- px_addr  out  15  framebuffer address, y*WIDTH+x.
- px_data  out  2  pixel shade.
- frame_start  out  1  one-cycle pulse when a frame starts.
- frame_done  out  1  one-cycle pulse when line HEIGHT-1 closes.
- err_line  out  1  pulse: a line closed with x != WIDTH.
- err_overrun  out  1  pulse: a pixel arrived with x == WIDTH; the pixel is dropped.
- err_frame  out  1  pulse: vsync arrived during ACTIVE before frame_done.

Behaviour:
- Reset (asynchronous):
  - All outputs 0; state IDLE; x=0, y=0.
  - Synchronizer and edge-detect flops cleared.
- Input sampling:
  - Every lcd_* input passes through SYNC_STAGES flops, then one edge-detect flop.
  - lcd_data shares the lcd_clk pipeline depth, so it is sampled aligned with the detected pclk edge.
- Outputs:
  - All outputs are registered.
  - Pin-to-px_valid latency is SYNC_STAGES+2 clk cycles.
- States:
  - IDLE: disp_on=0. Nothing is emitted. disp_on rising → WAIT_VSYNC.
  - WAIT_VSYNC:
    - pclk and latch edges are ignored.
    - vsync rising → ACTIVE with x=0, y=0, frame_start pulse.
  - ACTIVE:
    - pclk rise with x<WIDTH:
      - px_valid=1; px_x=x, px_y=y, px_addr=y*WIDTH+x; px_data = sampled data.
      - Then x++.
    - pclk rise with x==WIDTH: err_overrun pulse; no write; x holds.
    - latch rise:
      - err_line pulse if x != WIDTH; then x=0.
      - If y==HEIGHT-1: frame_done pulse, → WAIT_VSYNC, y=0.
      - Otherwise y++.
    - vsync rise: err_frame pulse, frame_start pulse, x=0, y=0, stay in ACTIVE.
- Any state: disp_on=0 → IDLE within one cycle. Counters clear; pending pulses are not emitted.
- Simultaneous edges, same clk cycle:
  - pclk + latch: the pixel is written to the current line first, then the line closes. The latch x check uses the post-increment x.
  - vsync + latch, or vsync + pclk: vsync wins; the latch/pixel is discarded.
- Widths:
  - px_addr computed as y*WIDTH+x with no truncation for the defaults; max value 23039 fits in 15 bits.
  - x and y never wrap.
- Reset mid-frame: immediate return to IDLE. Writes resume only after disp_on is high and a fresh vsync edge.
- hsync must be low in WAIT_VSYNC/IDLE.

Decomposition:
- Shared package lcd_pkg:
  - LCD_WIDTH=160, LCD_HEIGHT=144, LCD_ADDR_W=15.
  - State enum {IDLE, WAIT_VSYNC, ACTIVE}.
  - Pixel shade typedef (2 bits).
- Sub-module lcd_sync_edge: N-stage synchronizer plus rising-edge detector, with registered level and rise outputs. It is instantiated for vsync, latch and clk. lcd_data uses a plain 2-bit synchronizer of matching depth.

Test Plan:
- Full frame: disp_on=1, vsync edge, then 144 lines of 160 pclk edges (data = x mod 4) each closed by latch → 23040 px_valid pulses. Last write has px_addr=23039, px_data=3. Exactly one frame_start, one frame_done, no errors.
- Short line: line 5 gets 159 pixels then latch → err_line pulse on that latch. Line 6 starts at px_addr=960.
- Overrun: 161 pclk edges on line 0 → 160 writes, one err_overrun, 161st pixel dropped. latch gives no err_line.
- Early vsync: vsync at y=50 → err_frame and frame_start together. Next pixel has px_x=0, px_y=0, px_addr=0.
- Latency and coincidence:
  - Single pclk edge → px_valid exactly SYNC_STAGES+2 clk after the pin edge.
  - pclk and latch in the same sampled cycle at x=159 → pixel written at x=159, then y increments with no err_line.
- Reset/disp_on mid-frame: assert reset at y=70 → all outputs 0 immediately. Release with no vsync → no px_valid. Next vsync → frame restarts at 0,0. disp_on=0 mid-line → no further writes.
